// File: rtl/rom_pkg.sv
// Shared types and constants for the one-hot ROM scan path.
// Pure declarations: no latency, no flow control.
package rom_pkg;

  localparam int ROM_DEPTH  = 8;
  localparam int ROM_DATA_W = 8;
  localparam int SUM_W      = ROM_DATA_W + 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    GAP,
    DONE
  } scan_state_t;

  function automatic logic [ROM_DEPTH-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [ROM_DEPTH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rom_pace_cnt.sv
// Loadable down-counter timing the idle gap between ROM reads.
// Load/decrement take effect next edge; tc_o flags a count of 1; no backpressure.
module rom_pace_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rom_scan_seq.sv
// Walks all ROM words on start: one-hot address + 1-cycle enable, capture one cycle later, running sum.
// Word k enable at cycle 1+k*(2+PACE), valid at 3+k*(2+PACE); no backpressure, stop aborts to IDLE.
module rom_scan_seq
  import rom_pkg::*;
#(
  parameter int DATA_W    = ROM_DATA_W,
  parameter int NUM_WORDS = ROM_DEPTH,
  parameter int PACE      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  output logic [NUM_WORDS-1:0] addr_oneshot,
  output logic                 rom_en,
  input  logic [DATA_W-1:0]    rom_dout,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic [DATA_W+2:0]    sum_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);
  localparam logic [7:0] PACE_LD  = 8'(PACE);

  scan_state_t         state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [DATA_W+2:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                dv_q, dv_d;
  logic                pace_load, pace_dec, pace_tc;

  rom_pace_cnt #(
    .CNT_W (8)
  ) u_pace_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pace_load),
    .dec_i      (pace_dec),
    .load_val_i (PACE_LD),
    .tc_o       (pace_tc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    rom_en    = 1'b0;
    pace_load = 1'b0;
    pace_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          idx_d   = '0;
          sum_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          rom_en  = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // An abort here drops the word the ROM is presenting this cycle.
        if (stop) begin
          state_d = IDLE;
        end else begin
          data_d = rom_dout;
          dv_d   = 1'b1;
          sum_d  = sum_q + {3'b000, rom_dout};
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
            if (PACE > 0) begin
              pace_load = 1'b1;
              state_d   = GAP;
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pace_tc) begin
          state_d = ISSUE;
        end else begin
          pace_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
    end
  end

  // Decoded from the registered index so the address can never be all-zero.
  assign addr_oneshot = idx_to_onehot(idx_q);
  assign data_out     = data_q;
  assign data_valid   = dv_q;
  assign sum_out      = sum_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE) && !stop;

endmodule

// File: tb/tb_rom_scan_seq.sv
// Directed bench: two sequencers (PACE=0 and PACE=3), each feeding a registered ROM model holding 0x11..0x88.
module tb_rom_scan_seq;
  import rom_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, stop0 = 1'b0;
  logic        start3 = 1'b0, stop3 = 1'b0;

  logic [7:0]  addr0, addr3;
  logic        en0, en3;
  logic [7:0]  rom0 = '0, rom3 = '0;
  logic [7:0]  dat0, dat3;
  logic        dv0, dv3;
  logic [10:0] sum0, sum3;
  logic        busy0, busy3;
  logic        done0, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_scan_seq #(.DATA_W(8), .NUM_WORDS(8), .PACE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0),
    .addr_oneshot(addr0), .rom_en(en0), .rom_dout(rom0),
    .data_out(dat0), .data_valid(dv0), .sum_out(sum0),
    .busy(busy0), .done(done0)
  );

  rom_scan_seq #(.DATA_W(8), .NUM_WORDS(8), .PACE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stop(stop3),
    .addr_oneshot(addr3), .rom_en(en3), .rom_dout(rom3),
    .data_out(dat3), .data_valid(dv3), .sum_out(sum3),
    .busy(busy3), .done(done3)
  );

  function automatic logic [7:0] rom_word(input logic [7:0] oh);
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) w = 8'(17 * (i + 1));
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (en0) rom0 <= rom_word(addr0);
    if (en3) rom3 <= rom_word(addr3);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("onehot0", 32'($countones(addr0)), 32'd1);
    chk("onehot3", 32'($countones(addr3)), 32'd1);
  end

  task automatic chk_reset0(input string pfx);
    chk({pfx, " addr"}, 32'(addr0), 32'h01);
    chk({pfx, " rom_en"}, 32'(en0), 32'd0);
    chk({pfx, " data_out"}, 32'(dat0), 32'd0);
    chk({pfx, " data_valid"}, 32'(dv0), 32'd0);
    chk({pfx, " sum"}, 32'(sum0), 32'd0);
    chk({pfx, " busy"}, 32'(busy0), 32'd0);
    chk({pfx, " done"}, 32'(done0), 32'd0);
  endtask

  task automatic pulse_start(input int pace);
    @(posedge clk); #1;
    if (pace == 0) start0 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start3 = 1'b0;
  endtask

  // Full scan checked cycle by cycle; optionally re-pulses start in cycle 5.
  task automatic run_scan(input int pace, input bit restart);
    int p, last, k;
    logic en, dv, dn, bsy;
    logic [7:0] oh, dat;
    logic [10:0] sm;
    bit exp_en, exp_dv;
    p    = 2 + pace;
    last = 3 + 7 * p;
    pulse_start(pace);
    for (int c = 1; c <= last + 3; c++) begin
      @(negedge clk);
      en  = (pace == 0) ? en0   : en3;
      oh  = (pace == 0) ? addr0 : addr3;
      dv  = (pace == 0) ? dv0   : dv3;
      dat = (pace == 0) ? dat0  : dat3;
      dn  = (pace == 0) ? done0 : done3;
      bsy = (pace == 0) ? busy0 : busy3;
      sm  = (pace == 0) ? sum0  : sum3;
      exp_en = ((c - 1) % p == 0) && ((c - 1) / p < 8);
      exp_dv = (c >= 3) && ((c - 3) % p == 0) && ((c - 3) / p < 8);
      chk($sformatf("p%0d rom_en c%0d", pace, c), 32'(en), 32'(exp_en));
      if (exp_en) begin
        k = (c - 1) / p;
        chk($sformatf("p%0d addr c%0d", pace, c), 32'(oh), 32'(1) << k);
      end
      chk($sformatf("p%0d data_valid c%0d", pace, c), 32'(dv), 32'(exp_dv));
      if (exp_dv) begin
        k = (c - 3) / p;
        chk($sformatf("p%0d data c%0d", pace, c), 32'(dat), 32'(17 * (k + 1)));
      end
      chk($sformatf("p%0d done c%0d", pace, c), 32'(dn), 32'(c == last));
      chk($sformatf("p%0d busy c%0d", pace, c), 32'(bsy), 32'(c <= last));
      if (c >= last) chk($sformatf("p%0d sum c%0d", pace, c), 32'(sm), 32'h264);
      if (restart && c == 4) begin @(posedge clk); #1; start0 = 1'b1; end
      if (restart && c == 5) begin @(posedge clk); #1; start0 = 1'b0; end
    end
  endtask

  initial begin
    #12;
    chk_reset0("reset");
    chk("reset addr3", 32'(addr3), 32'h01);
    chk("reset busy3", 32'(busy3), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle rom_en", 32'(en0), 32'd0);

    run_scan(0, 1'b0);
    run_scan(3, 1'b0);
    run_scan(0, 1'b1);

    // Abort during the ISSUE cycle of word 4, after word 3 was captured.
    pulse_start(0);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    stop0 = 1'b1;
    @(negedge clk);
    chk("stop rom_en forced", 32'(en0), 32'd0);
    chk("stop busy", 32'(busy0), 32'd1);
    @(posedge clk); #1;
    stop0 = 1'b0;
    @(negedge clk);
    chk("stop idle", 32'(busy0), 32'd0);
    chk("stop data_out", 32'(dat0), 32'h44);
    chk("stop sum", 32'(sum0), 32'hAA);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("stop no done %0d", c), 32'(done0), 32'd0);
      chk($sformatf("stop no rom_en %0d", c), 32'(en0), 32'd0);
    end
    chk("stop sum held", 32'(sum0), 32'hAA);

    // Asynchronous reset in the CAPTURE cycle of word 2.
    pulse_start(0);
    repeat (6) @(negedge clk);
    chk("pre-rst busy", 32'(busy0), 32'd1);
    chk("pre-rst addr", 32'(addr0), 32'h04);
    #2 rst_n = 1'b0;
    #1 chk_reset0("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst busy", 32'(busy0), 32'd0);
    run_scan(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
